rs_driver: RTL and testbench

//   Synchronous command stage directly upstream of the NOR RS latch (drives its R/S, reads back Q/NQ).

---
 rtl/rs_driver.sv | 157 +++++++++++++++
 tb/tb_rs_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_driver.sv
// Command stage for a NOR RS latch: turns set/reset requests into non-overlapping,
// fixed-width R/S pulses, waits out a settle gap, then verifies the synchronised readback.
module rs_driver #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_REQ,
    input  logic RST_REQ,
    input  logic Q,
    input  logic NQ,
    output logic R,
    output logic S,
    output logic BUSY,
    output logic DONE,
    output logic ERR
);
    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_W - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, CHECK} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          cmd_set_reg, cmd_set_next;
    logic          pend_valid_reg, pend_valid_next;
    logic          pend_set_reg, pend_set_next;
    logic          r_reg, s_reg, busy_reg, done_reg, err_reg;
    logic          r_next, s_next, busy_next, done_next, err_next;

    logic [1:0] latch_raw;
    logic [1:0] latch_sync;
    logic       req, req_set, readback_bad;

    // Two-flop synchronisers for the asynchronous latch outputs (bit 0 = Q, bit 1 = NQ).
    assign latch_raw = {NQ, Q};
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic sync1_reg, sync2_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= latch_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end
            assign latch_sync[gi] = sync2_reg;
        end
    endgenerate

    // Simultaneous set and reset requests resolve to a reset command.
    assign req     = SET_REQ | RST_REQ;
    assign req_set = SET_REQ & ~RST_REQ;

    assign readback_bad = cmd_set_reg ? !( latch_sync[0] && !latch_sync[1])
                                      : !(!latch_sync[0] &&  latch_sync[1]);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        cmd_set_next    = cmd_set_reg;
        pend_valid_next = pend_valid_reg;
        pend_set_next   = pend_set_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next   = DRIVE;
                    cnt_next     = PULSE_LOAD;
                    cmd_set_next = req_set;
                end
            end
            DRIVE: begin
                if (req) begin
                    pend_valid_next = 1'b1;
                    pend_set_next   = req_set;
                end
                if (cnt_reg == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            GAP: begin
                if (req) begin
                    pend_valid_next = 1'b1;
                    pend_set_next   = req_set;
                end
                if (cnt_reg == '0) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            CHECK: begin
                // Pending command wins; a same-cycle request takes its place in the slot.
                if (pend_valid_reg) begin
                    state_next      = DRIVE;
                    cnt_next        = PULSE_LOAD;
                    cmd_set_next    = pend_set_reg;
                    pend_valid_next = req;
                    pend_set_next   = req_set;
                end else if (req) begin
                    state_next   = DRIVE;
                    cnt_next     = PULSE_LOAD;
                    cmd_set_next = req_set;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        s_next    = (state_next == DRIVE) &&  cmd_set_next;
        r_next    = (state_next == DRIVE) && !cmd_set_next;
        busy_next = (state_next != IDLE);
        done_next = (state_next == CHECK);
        err_next  = err_reg | ((state_next == CHECK) && readback_bad);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            cmd_set_reg    <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_set_reg   <= 1'b0;
            r_reg          <= 1'b0;
            s_reg          <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            cmd_set_reg    <= cmd_set_next;
            pend_valid_reg <= pend_valid_next;
            pend_set_reg   <= pend_set_next;
            r_reg          <= r_next;
            s_reg          <= s_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    assign R    = r_reg;
    assign S    = s_reg;
    assign BUSY = busy_reg;
    assign DONE = done_reg;
    assign ERR  = err_reg;
endmodule

// File: tb/tb_rs_driver.sv
// Scoreboard bench for rs_driver: a timeline model of accepted commands predicts R/S/BUSY
// per cycle and the DONE/readback/ERR response of each command; a NOR latch model closes the loop.
module tb_rs_driver;
    localparam int P = 2;
    localparam int G = 3;

    logic CLK, RST, SET_REQ, RST_REQ;
    logic R, S, BUSY, DONE, ERR;
    logic q_w, nq_w;

    bit latch_q   = 1'b0;
    bit force_bad = 1'b0;

    rs_driver #(.PULSE_W(P), .GAP_W(G)) dut (
        .CLK(CLK), .RST(RST), .SET_REQ(SET_REQ), .RST_REQ(RST_REQ),
        .Q(q_w), .NQ(nq_w), .R(R), .S(S), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    // NOR latch: S alone sets, R alone resets, neither holds.
    always @(R or S) begin
        if (S === 1'b1 && R !== 1'b1) latch_q = 1'b1;
        else if (R === 1'b1 && S !== 1'b1) latch_q = 1'b0;
    end
    assign q_w  = force_bad ? 1'b0 : latch_q;
    assign nq_w = force_bad ? 1'b0 : ~latch_q;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int done_edge;
        bit exp_q;
        bit exp_err;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;

    // Reference model: the command currently occupying the timeline plus a one-deep pending slot.
    bit cur_valid = 1'b0;
    int cur_start = 0;
    bit cur_cmd   = 1'b0;
    bit pend_v    = 1'b0;
    bit pend_c    = 1'b0;
    bit model_err = 1'b0;
    bit err_vis   = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, edge_n, act, exp);
        end
    endtask

    task automatic launch(input bit c);
        exp_t e;
        cur_valid   = 1'b1;
        cur_start   = edge_n;
        cur_cmd     = c;
        model_err   = model_err | force_bad;
        e.done_edge = edge_n + P + G;
        e.exp_q     = force_bad ? 1'b0 : c;
        e.exp_err   = model_err;
        sb.push_back(e);
        $display("cmd %s launched at edge %0d, DONE expected at %0d", c ? "SET" : "RESET", edge_n, e.done_edge);
    endtask

    task automatic step(input bit s, input bit r, input bit rst);
        int chk_edge;
        bit req, rc;
        req = s | r;
        rc  = s & ~r;
        if (rst) begin
            cur_valid = 1'b0;
            pend_v    = 1'b0;
            sb.delete();
            model_err = 1'b0;
            err_vis   = 1'b0;
            return;
        end
        chk_edge = cur_start + P + G + 1;
        if (cur_valid && edge_n < chk_edge) begin
            if (req) begin
                pend_v = 1'b1;
                pend_c = rc;
            end
        end else if (cur_valid && edge_n == chk_edge) begin
            if (pend_v) begin
                launch(pend_c);
                pend_v = req;
                pend_c = rc;
            end else if (req) launch(rc);
            else cur_valid = 1'b0;
        end else begin
            if (req) launch(rc);
            else cur_valid = 1'b0;
        end
    endtask

    task automatic cyc(input bit s, input bit r, input bit rst);
        @(negedge CLK);
        SET_REQ = s;
        RST_REQ = r;
        RST     = rst;
        @(posedge CLK);
        edge_n++;
        step(s, r, rst);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle against the model, pops the scoreboard on DONE.
    initial begin
        int  n;
        int  zeros;
        bit  prev_pulse;
        bit  pulse;
        bit  exp_s, exp_r, exp_busy, exp_done;
        exp_t it;
        zeros      = 100;
        prev_pulse = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                n        = edge_n;
                exp_s    = cur_valid && n >= cur_start && n < cur_start + P &&  cur_cmd;
                exp_r    = cur_valid && n >= cur_start && n < cur_start + P && !cur_cmd;
                exp_busy = cur_valid && n <= cur_start + P + G;
                exp_done = cur_valid && n == cur_start + P + G;
                check("S", S, exp_s);
                check("R", R, exp_r);
                check("BUSY", BUSY, exp_busy);
                check("r_and_s", R & S, 1'b0);
                pulse = (R === 1'b1) || (S === 1'b1);
                if (pulse && !prev_pulse) check_int("gap_before_pulse", (zeros >= G) ? 1 : 0, 1);
                zeros      = pulse ? 0 : zeros + 1;
                prev_pulse = pulse;
                if (DONE === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected cycle=%0d actual=1 expected=0", n);
                    end else begin
                        it = sb.pop_front();
                        check_int("done_time", n, it.done_edge);
                        check("done_q", q_w, it.exp_q);
                        err_vis = it.exp_err;
                        $display("DONE at %0d q=%b err=%b", n, q_w, ERR);
                    end
                end else if (exp_done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_missing cycle=%0d actual=0 expected=1", n);
                end
                check("ERR", ERR, err_vis);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv;
        SET_REQ = 1'b0;
        RST_REQ = 1'b0;
        RST     = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        check("reset_busy", BUSY, 1'b0);
        check("reset_err", ERR, 1'b0);
        idle(2);

        // Single set, then simultaneous set+reset (reset dominant).
        cyc(1'b1, 1'b0, 1'b0);
        idle(8);
        cyc(1'b1, 1'b1, 1'b0);
        idle(8);

        // Set, then a reset request two cycles later while busy: back-to-back via pending slot.
        cyc(1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0);
        idle(14);

        // Broken readback during a set, then good commands: ERR must stay sticky.
        force_bad = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        idle(8);
        force_bad = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        idle(8);
        cyc(1'b1, 1'b0, 1'b0);
        idle(8);

        // Reset in the second S cycle with a request pending: everything dropped.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(10);

        // Randomised request traffic.
        repeat (400) begin
            rv = int'($urandom_range(0, 9));
            cyc(rv < 2 || rv == 4, rv == 2 || rv == 3 || rv == 4, 1'b0);
        end
        idle(20);

        check_int("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
